mips_cpu_register_file_mp: RTL
==============================

# mips_cpu_register_file_mp

Parametrised multi-port register file for the multicycle MIPS CPU. It generalises the 2-read/1-write file to NUM_READ read ports and two write ports: port C for ALU writeback and port D for late load writeback. A per-register pending scoreboard lets the control FSM mark a register as awaiting a load, so dependent reads can stall. An optional write-to-read bypass is available. Register 0 reads as zero and is never pending.

## Interface
- DATA_W, 32: register width in bits.
- DEPTH, 32: number of registers, a power of two ≥ 2; AW = $clog2(DEPTH).
- NUM_READ, 2: number of read ports, 1..4.
- clk  in  1  clock; every state change happens on its rising edge.
- reset  in  1  synchronous, active-high reset.
- register_v0  out  DATA_W  combinational view of register 2.
- read_addr  in  NUM_READ*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- read_data  out  NUM_READ*DATA_W  packed read data, same packing.
- read_busy  out  NUM_READ  port k's addressed register is pending.
- write_addr_c, write_enable_c, write_data_c  in  AW/1/DATA_W  write port C.
- write_addr_d, write_enable_d, write_data_d  in  AW/1/DATA_W  write port D; a write here also clears pending.
- reserve_addr, reserve_enable  in  AW/1  sets the pending bit of the addressed register.
- any_pending  out  1  OR of all pending bits.

## Operation
- Storage is regs[DEPTH] of DATA_W bits plus pending[DEPTH], one bit per register.
- Reset (sampled on an edge):
  - All regs and pending bits clear to 0.
  - While reset is high, register_v0, read_data, read_busy and any_pending are forced to 0.
- Write port C: when enabled with a nonzero address, regs[addr_c] <= data_c. Pending is unchanged.
- Write port D: when enabled with a nonzero address:
  - regs[addr_d] <= data_d.
  - pending[addr_d] <= 0.
- Reserve: when enabled with a nonzero address, pending[reserve_addr] <= 1.
- Any access to address 0 is ignored. regs[0] and pending[0] stay 0.
- Same-edge conflicts:
  - C and D to the same address: C's data is stored, and the pending bit is still cleared.
  - Reserve and D to the same address: D's data is stored and pending ends at 1 (reserve wins).
  - Reserve and C to the same address: C's data is stored and pending ends at 1.
- Reads: read_data[k] = regs[read_addr[k]]. read_busy[k] = pending[read_addr[k]]. Address 0 gives data 0, busy 0.
- Reserving an already-pending register is legal and leaves it at 1.
- Writing port D to a non-pending register is legal; it writes the data and leaves pending at 0.

## Timing
- Reads are combinational, with zero latency.
- Writes and reserves take effect on the rising edge and are visible in the next cycle.
- Without bypass, a read in the same cycle as a write returns the old value and the old busy bit.
- The first cycle after reset deassertion reads all zeros.
- A reset asserted mid-sequence (with a reserve outstanding) discards everything. Any write presented on the reset edge is dropped.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address equals an enabled, nonzero write address returns that write's data in the same cycle. Port C has priority over port D.
  - A port D write to the read address forces read_busy[k] to 0 in that cycle, unless reserve_enable targets the same address.
  - register_v0 is bypassed the same way.
- REGFILE_BYPASS_EN undefined: reads are purely registered-state, as described in Timing.

## Test plan
- Reset, then read every address on all ports → all data 0, busy 0, any_pending 0. Write port C addr 0 = 0xDEADBEEF → address 0 still reads 0.
- Port C writes addr 2 = 0x00000005 → next cycle register_v0 = 5 and read_data[0] at addr 2 = 5. With bypass, the value appears in the write cycle; without bypass, the old value 0 is returned in that cycle.
- Reserve addr 8 → next cycle read_busy = 1 and any_pending = 1. Then port D writes addr 8 = 0x12345678 → next cycle busy 0 and data 0x12345678.
- Same edge: C addr 9 = 0xAAAA0000, D addr 9 = 0x5555FFFF, reserve addr 9 → data 0xAAAA0000, busy 1.
- Reserve addr 3 and C write addr 4 = 7, then assert reset for one cycle together with D addr 3 = 1 → afterwards addr 3 = 0, not busy, and addr 4 = 0.
- With DEPTH=16, NUM_READ=4, DATA_W=16: write addrs 1..15 with value addr*3 and read them back on all four ports concurrently → every port matches. Addr 15 returns 45; there is no wrap-around.

Source files
------------

// File: rtl/mips_cpu_register_file_mp.sv
// Multi-port register file with a load-pending scoreboard for the multicycle MIPS CPU.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module mips_cpu_register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [DATA_W-1:0]          register_v0,
    input  logic [NUM_READ*AW-1:0]     read_addr,
    output logic [NUM_READ*DATA_W-1:0] read_data,
    output logic [NUM_READ-1:0]        read_busy,
    input  logic [AW-1:0]              write_addr_c,
    input  logic                       write_enable_c,
    input  logic [DATA_W-1:0]          write_data_c,
    input  logic [AW-1:0]              write_addr_d,
    input  logic                       write_enable_d,
    input  logic [DATA_W-1:0]          write_data_d,
    input  logic [AW-1:0]              reserve_addr,
    input  logic                       reserve_enable,
    output logic                       any_pending
);

    // With DEPTH == 2 this truncates to address 0, so register_v0 reads 0.
    localparam logic [AW-1:0] V0_ADDR = AW'(2);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending_q, pending_d;

    logic c_hit_en, d_hit_en, r_hit_en;
    assign c_hit_en = write_enable_c && (write_addr_c != '0);
    assign d_hit_en = write_enable_d && (write_addr_d != '0);
    assign r_hit_en = reserve_enable && (reserve_addr != '0);

    // NOTE: blocking assignments in always_comb execute in order, so the later
    // lines win; that ordering encodes C-over-D data and reserve-over-clear.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (d_hit_en) begin
            regs_d[write_addr_d]    = write_data_d;
            pending_d[write_addr_d] = 1'b0;
        end
        if (c_hit_en) regs_d[write_addr_c] = write_data_c;
        if (r_hit_en) pending_d[reserve_addr] = 1'b1;
    end

    // NOTE: the storage array is reset explicitly because a reset must leave
    // every register reading zero; this keeps it out of plain RAM inference.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q    <= '{default: '0};
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_word(input logic [AW-1:0] a);
        logic [DATA_W-1:0] w;
        w = (a == '0) ? '0 : regs_q[a];
`ifdef REGFILE_BYPASS_EN
        if (c_hit_en && write_addr_c == a) w = write_data_c;
        else if (d_hit_en && write_addr_d == a) w = write_data_d;
`endif
        return w;
    endfunction

    function automatic logic read_pend(input logic [AW-1:0] a);
        logic p;
        p = (a == '0) ? 1'b0 : pending_q[a];
`ifdef REGFILE_BYPASS_EN
        // A landing load clears busy early unless it is re-reserved on the same edge.
        if (d_hit_en && write_addr_d == a && !(r_hit_en && reserve_addr == a)) p = 1'b0;
`endif
        return p;
    endfunction

    // NOTE: every output gets a default first so no path through the block
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        read_data   = '0;
        read_busy   = '0;
        register_v0 = '0;
        any_pending = 1'b0;
        if (!reset) begin
            for (int k = 0; k < NUM_READ; k++) begin
                read_data[k*DATA_W +: DATA_W] = read_word(read_addr[k*AW +: AW]);
                read_busy[k]                  = read_pend(read_addr[k*AW +: AW]);
            end
            register_v0 = read_word(V0_ADDR);
            any_pending = |pending_q;
        end
    end

endmodule
